// File: rtl/zap_ram_ben_ctrl.sv
// Sequencing/arbitration controller for a byte-enabled 3-cycle-latency dual-port RAM.
// Define ZAP_RAM_BEN_CTRL_INIT_EN to zero-fill the RAM after every reset.
module zap_ram_ben_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_hold,
  input  logic                       i_wr_req,
  input  logic [WIDTH/8-1:0]         i_wr_ben,
  input  logic [$clog2(DEPTH)-1:0]   i_wr_addr,
  input  logic [WIDTH-1:0]           i_wr_data,
  output logic                       o_wr_ack,
  input  logic [1:0]                 i_rd_req,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_addr0,
  input  logic [$clog2(DEPTH)-1:0]   i_rd_addr1,
  output logic [1:0]                 o_rd_ack,
  output logic [1:0]                 o_rd_valid,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_init_done,
  output logic                       o_busy,
  output logic                       o_ram_clken,
  output logic [WIDTH/8-1:0]         o_ram_wr_en,
  output logic [$clog2(DEPTH)-1:0]   o_ram_wr_addr,
  output logic [WIDTH-1:0]           o_ram_wr_data,
  output logic [$clog2(DEPTH)-1:0]   o_ram_rd_addr,
  input  logic [WIDTH-1:0]           i_ram_rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic          run;
  logic [AW-1:0] initAddr;

`ifdef ZAP_RAM_BEN_CTRL_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] initCnt_q, initCnt_d;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_INIT;
      initCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      initCnt_q <= initCnt_d;
    end
  end

  // Zero-fill walks the whole RAM, one word per unheld cycle, then hands over to RUN.
  always_comb begin
    state_d   = state_q;
    initCnt_d = initCnt_q;
    if (state_q == ST_INIT && !i_hold) begin
      initCnt_d = initCnt_q + AW'(1);
      if (initCnt_q == AW'(DEPTH - 1)) state_d = ST_RUN;
    end
  end

  assign run      = (state_q == ST_RUN);
  assign initAddr = initCnt_q;
`else
  assign run      = 1'b1;
  assign initAddr = '0;
`endif

  logic       prio_q, prio_d;
  logic       gntVld, gntId;
  logic [2:0] tagVld_q, tagId_q;

  // Round-robin between the two readers; prio points at whoever lost last time.
  always_comb begin
    gntVld = 1'b0;
    gntId  = 1'b0;
    prio_d = prio_q;
    if (run && !i_hold) begin
      case (i_rd_req)
        2'b11:   begin gntVld = 1'b1; gntId = prio_q; end
        2'b01:   begin gntVld = 1'b1; gntId = 1'b0;   end
        2'b10:   begin gntVld = 1'b1; gntId = 1'b1;   end
        default: ;
      endcase
      if (gntVld) prio_d = ~gntId;
    end
  end

  // Tag pipeline mirrors the RAM read latency; index 0 is s1, index 2 is s3.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prio_q   <= 1'b0;
      tagVld_q <= '0;
      tagId_q  <= '0;
    end else begin
      prio_q <= prio_d;
      if (o_ram_clken) begin
        tagVld_q <= {tagVld_q[1:0], gntVld};
        tagId_q  <= {tagId_q[1:0], gntId};
      end
    end
  end

  assign o_ram_clken   = ~i_hold;
  assign o_wr_ack      = run & i_wr_req & ~i_hold;
  assign o_rd_ack      = gntVld ? (gntId ? 2'b10 : 2'b01) : 2'b00;
  assign o_ram_rd_addr = (gntVld && gntId) ? i_rd_addr1 : i_rd_addr0;
  assign o_rd_valid    = (tagVld_q[2] && !i_hold) ? (tagId_q[2] ? 2'b10 : 2'b01) : 2'b00;
  assign o_rd_data     = i_ram_rd_data;
  assign o_busy        = |tagVld_q;
  assign o_init_done   = run;

  // Outside RUN the write port belongs to the zero-fill sequencer.
  assign o_ram_wr_en   = run ? (o_wr_ack ? i_wr_ben : '0) : '1;
  assign o_ram_wr_addr = run ? i_wr_addr : initAddr;
  assign o_ram_wr_data = run ? i_wr_data : '0;

endmodule

// File: tb/tb_zap_ram_ben_ctrl.sv
// Randomized bench for zap_ram_ben_ctrl: a behavioural RAM drives the read data,
// and a queue-based reference model predicts every controller output each cycle.
module tb_zap_ram_ben_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);
  localparam int NB    = WIDTH / 8;

  logic             clk = 1'b0;
  logic             i_reset_n;
  logic             i_hold;
  logic             i_wr_req;
  logic [NB-1:0]    i_wr_ben;
  logic [AW-1:0]    i_wr_addr;
  logic [WIDTH-1:0] i_wr_data;
  logic             o_wr_ack;
  logic [1:0]       i_rd_req;
  logic [AW-1:0]    i_rd_addr0, i_rd_addr1;
  logic [1:0]       o_rd_ack, o_rd_valid;
  logic [WIDTH-1:0] o_rd_data;
  logic             o_init_done, o_busy, o_ram_clken;
  logic [NB-1:0]    o_ram_wr_en;
  logic [AW-1:0]    o_ram_wr_addr, o_ram_rd_addr;
  logic [WIDTH-1:0] o_ram_wr_data;
  logic [WIDTH-1:0] i_ram_rd_data;

  always #5 clk = ~clk;

  zap_ram_ben_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_reset_n     (i_reset_n),
    .i_hold        (i_hold),
    .i_wr_req      (i_wr_req),
    .i_wr_ben      (i_wr_ben),
    .i_wr_addr     (i_wr_addr),
    .i_wr_data     (i_wr_data),
    .o_wr_ack      (o_wr_ack),
    .i_rd_req      (i_rd_req),
    .i_rd_addr0    (i_rd_addr0),
    .i_rd_addr1    (i_rd_addr1),
    .o_rd_ack      (o_rd_ack),
    .o_rd_valid    (o_rd_valid),
    .o_rd_data     (o_rd_data),
    .o_init_done   (o_init_done),
    .o_busy        (o_busy),
    .o_ram_clken   (o_ram_clken),
    .o_ram_wr_en   (o_ram_wr_en),
    .o_ram_wr_addr (o_ram_wr_addr),
    .o_ram_wr_data (o_ram_wr_data),
    .o_ram_rd_addr (o_ram_rd_addr),
    .i_ram_rd_data (i_ram_rd_data)
  );

  // Known power-up contents shared by the RAM and the reference memory.
  function automatic logic [WIDTH-1:0] seedWord(input int i);
    return WIDTH'(32'h5A3C96E1 ^ (i * 32'h01030507));
  endfunction

  // Behavioural RAM: writes land on the edge, read address travels 3 enabled edges.
  logic [WIDTH-1:0] ramMem [DEPTH];
  logic [AW-1:0]    ramA1, ramA2, ramA3;
  bit               ramLoaded = 1'b0;

  always @(posedge clk) begin
    if (!ramLoaded) begin
      for (int i = 0; i < DEPTH; i++) ramMem[i] <= seedWord(i);
      ramA1     <= '0;
      ramA2     <= '0;
      ramA3     <= '0;
      ramLoaded <= 1'b1;
    end else if (o_ram_clken) begin
      for (int b = 0; b < NB; b++)
        if (o_ram_wr_en[b]) ramMem[o_ram_wr_addr][b*8 +: 8] <= o_ram_wr_data[b*8 +: 8];
      ramA1 <= o_ram_rd_addr;
      ramA2 <= ramA1;
      ramA3 <= ramA2;
    end
  end

  assign i_ram_rd_data = ramMem[ramA3];

  // Reference model: memory image, pending reads with their age in unheld cycles.
  typedef struct {
    int id;
    int addr;
    int age;
  } rdEntry_t;

  logic [WIDTH-1:0] refMem [DEPTH];
  rdEntry_t         pend[$];
  int               prioM;
  bit               runM;
  int               initCntM;
  int               numChecks;
  int               numFail;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFail++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic resetModel();
    pend.delete();
    prioM    = 0;
    initCntM = 0;
`ifdef ZAP_RAM_BEN_CTRL_INIT_EN
    runM = 1'b0;
`else
    runM = 1'b1;
`endif
  endtask

  // mode 0: general random, 1: both readers always requesting, 2: hot addresses, 3: heavy hold
  task automatic applyStimulus(input int mode);
    case (mode)
      1:       i_hold = 1'b0;
      2:       i_hold = ($urandom_range(5, 0) == 0);
      3:       i_hold = ($urandom_range(1, 0) == 1);
      default: i_hold = ($urandom_range(7, 0) == 0);
    endcase
    i_wr_req  = (mode == 2) ? ($urandom_range(3, 0) != 0) : ($urandom_range(1, 0) == 1);
    i_wr_ben  = ($urandom_range(15, 0) == 0) ? '0 : NB'($urandom);
    i_wr_data = WIDTH'($urandom);
    i_rd_req  = (mode == 1) ? 2'b11 : 2'($urandom);
    if (mode == 2) begin
      i_wr_addr  = AW'($urandom_range(3, 0));
      i_rd_addr0 = AW'($urandom_range(3, 0));
      i_rd_addr1 = AW'($urandom_range(3, 0));
    end else begin
      i_wr_addr  = AW'($urandom_range(DEPTH - 1, 0));
      i_rd_addr0 = AW'($urandom_range(DEPTH - 1, 0));
      i_rd_addr1 = AW'($urandom_range(DEPTH - 1, 0));
    end
  endtask

  task automatic runCycle(input int mode);
    int               g;
    int               dIdx;
    logic             expWrAck;
    logic [1:0]       expRdAck, expValid;
    logic [AW-1:0]    expRdAddr;
    logic [NB-1:0]    expWrEn;
    rdEntry_t         nq[$];
    rdEntry_t         e;
    @(negedge clk);
    i_reset_n = 1'b1;
    applyStimulus(mode);
    #1;
    expWrAck = runM && i_wr_req && !i_hold;
    g = -1;
    if (runM && !i_hold) begin
      if (i_rd_req == 2'b11)  g = prioM;
      else if (i_rd_req[0])   g = 0;
      else if (i_rd_req[1])   g = 1;
    end
    expRdAck  = (g < 0) ? 2'b00 : 2'(1 << g);
    expRdAddr = (g == 1) ? i_rd_addr1 : i_rd_addr0;
    dIdx = -1;
    foreach (pend[i]) if (pend[i].age == 3) dIdx = i;
    expValid = (dIdx >= 0 && !i_hold) ? 2'(1 << pend[dIdx].id) : 2'b00;
    expWrEn  = runM ? (expWrAck ? i_wr_ben : '0) : '1;

    checkOutput("wr_ack", 64'(o_wr_ack), 64'(expWrAck));
    checkOutput("rd_ack", 64'(o_rd_ack), 64'(expRdAck));
    checkOutput("ram_rd_addr", 64'(o_ram_rd_addr), 64'(expRdAddr));
    checkOutput("rd_valid", 64'(o_rd_valid), 64'(expValid));
    if (expValid != 2'b00)
      checkOutput("rd_data", 64'(o_rd_data), 64'(refMem[pend[dIdx].addr]));
    checkOutput("busy", 64'(o_busy), 64'(pend.size() != 0));
    checkOutput("init_done", 64'(o_init_done), 64'(runM));
    checkOutput("ram_clken", 64'(o_ram_clken), 64'(!i_hold));
    checkOutput("ram_wr_en", 64'(o_ram_wr_en), 64'(expWrEn));
    checkOutput("ram_wr_addr", 64'(o_ram_wr_addr), runM ? 64'(i_wr_addr) : 64'(initCntM));
    checkOutput("ram_wr_data", 64'(o_ram_wr_data), runM ? 64'(i_wr_data) : 64'd0);

    // Everything in the model advances only on unheld cycles.
    if (!i_hold) begin
      foreach (pend[i]) begin
        if (pend[i].age < 3) begin
          e = pend[i];
          e.age++;
          nq.push_back(e);
        end
      end
      if (g >= 0) begin
        e.id   = g;
        e.addr = (g == 1) ? int'(i_rd_addr1) : int'(i_rd_addr0);
        e.age  = 1;
        nq.push_back(e);
        prioM = 1 - g;
      end
      pend = nq;
      if (runM) begin
        if (expWrAck)
          for (int b = 0; b < NB; b++)
            if (i_wr_ben[b]) refMem[i_wr_addr][b*8 +: 8] = i_wr_data[b*8 +: 8];
      end else begin
        refMem[initCntM] = '0;
        initCntM++;
        if (initCntM == DEPTH) runM = 1'b1;
      end
    end
  endtask

  task automatic zeroInputs();
    i_hold   = 1'b0;
    i_wr_req = 1'b0;
    i_wr_ben = '0;
    i_rd_req = 2'b00;
  endtask

  // Fill the read pipeline, then yank reset with reads in flight.
  task automatic doMidReset();
    for (int k = 0; k < 3; k++) runCycle(1);
    @(negedge clk);
    i_reset_n = 1'b0;
    zeroInputs();
    resetModel();
    #1;
    checkOutput("mid_rst_rd_valid", 64'(o_rd_valid), 64'(pend.size() != 0));
    checkOutput("mid_rst_busy", 64'(o_busy), 64'(pend.size() != 0));
    @(negedge clk);
  endtask

  initial begin
    numChecks = 0;
    numFail   = 0;
    for (int i = 0; i < DEPTH; i++) refMem[i] = seedWord(i);
    i_reset_n  = 1'b0;
    i_wr_addr  = '0;
    i_wr_data  = '0;
    i_rd_addr0 = '0;
    i_rd_addr1 = '0;
    zeroInputs();
    resetModel();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_rd_valid", 64'(o_rd_valid), 64'd0);
    checkOutput("rst_busy", 64'(o_busy), 64'd0);
    checkOutput("rst_init_done", 64'(o_init_done), 64'(runM));
    checkOutput("rst_wr_ack", 64'(o_wr_ack), 64'd0);
    checkOutput("rst_rd_ack", 64'(o_rd_ack), 64'd0);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 700 == 699) doMidReset();
      runCycle((cyc / 250) % 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFail);
    $finish;
  end

endmodule

// File: doc/zap_ram_ben_ctrl.md
# zap_ram_ben_ctrl

Sequencing and arbitration controller for a byte-enabled, pipelined simple dual-port RAM with 3-cycle read latency and a shared clock enable. Accepts one write port and two read requesters, and grants at most one read per cycle using round-robin arbitration. Tracks in-flight reads through a 3-stage tag pipeline and returns read data to the requester that issued it. Optionally zero-fills the RAM after reset before accepting traffic.

## Interface
- `WIDTH`, 32: RAM data width in bits; multiple of 8.
- `DEPTH`, 32: RAM depth in words; power of 2, ≥2.

- `i_clk`  in  1  clock.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_hold`  in  1  freeze: RAM clock enable low, no acks, tag pipeline frozen.
- `i_wr_req`  in  1  write request.
- `i_wr_ben`  in  WIDTH/8  write byte enables.
- `i_wr_addr`  in  $clog2(DEPTH)  write address.
- `i_wr_data`  in  WIDTH  write data.
- `o_wr_ack`  out  1  write accepted this cycle (combinational).
- `i_rd_req`  in  2  read request per requester.
- `i_rd_addr0`, `i_rd_addr1`  in  $clog2(DEPTH)  read addresses.
- `o_rd_ack`  out  2  one-hot read grant this cycle (combinational).
- `o_rd_valid`  out  2  one-hot: `o_rd_data` belongs to this requester.
- `o_rd_data`  out  WIDTH  read data; passthrough of `i_ram_rd_data`.
- `o_init_done`  out  1  controller is in RUN.
- `o_busy`  out  1  any read is in flight.
- `o_ram_clken`  out  1  RAM clock enable.
- `o_ram_wr_en`  out  WIDTH/8  RAM byte write enables.
- `o_ram_wr_addr`  out  $clog2(DEPTH)  RAM write address.
- `o_ram_wr_data`  out  WIDTH  RAM write data.
- `o_ram_rd_addr`  out  $clog2(DEPTH)  RAM read address.
- `i_ram_rd_data`  in  WIDTH  RAM 3-cycle-delayed read data.

## Operation
- **States.** INIT and RUN.
  - Reset enters INIT, or RUN if the init feature is compiled out.
  - INIT → RUN on the cycle after the write to address DEPTH-1 (only if that cycle was not held).
  - RUN has no exit except reset.
- **INIT.**
  - Drives `o_ram_wr_en` all-ones, `o_ram_wr_data` = 0, `o_ram_wr_addr` = init counter.
  - Counter starts at 0 and increments on each non-held cycle.
  - All acks are 0. `o_init_done` = 0.
- **RUN, writes.**
  - `o_wr_ack` = `i_wr_req` & ~`i_hold`.
  - `o_ram_wr_en` = `o_wr_ack` ? `i_wr_ben` : 0.
  - Write address and data pass through.
  - A request with `i_wr_ben` = 0 is acked and has no effect.
  - Writes never conflict with reads; the RAM resolves same-address hazards.
- **RUN, reads.**
  - Round-robin pointer `prio` resets to 0.
  - Both requesting: grant requester `prio`.
  - One requesting: grant that requester.
  - After any grant, `prio` ← the non-granted index.
  - `o_ram_rd_addr` = address of the granted requester; `i_rd_addr0` when there is no grant.
  - No acks while `i_hold` = 1.
- **Tag pipeline.**
  - Stages s1..s3, each holding {valid, id}.
  - s1 ← {grant, id}; s2 ← s1; s3 ← s2. Advances only when `o_ram_clken` = 1.
  - `o_rd_valid[id]` = s3.valid & ~`i_hold`.
  - `o_busy` = OR of s1..s3 valid.
- **Clock enable.** `o_ram_clken` = ~`i_hold`, in both states.
- **Reset values.** Tags invalid, `prio` = 0, init counter = 0, `o_init_done` = 0 (1 without the feature), `o_rd_valid` = 0, all acks 0.
- **Reset mid-operation.** In-flight reads are discarded. With the feature, init restarts from address 0.

## Timing
- A read acked in cycle T presents `o_rd_valid` and data in cycle T+3, provided no hold occurs.
- Each held cycle adds one cycle of latency.
- While held, the s3 entry is masked; it reappears on the first unheld cycle and is delivered exactly once.
- Sustained throughput: one read and one write per cycle.
- Each requester receives at least one grant in any 2 consecutive contended cycles.
- INIT lasts DEPTH unheld cycles.
- Back-to-back reads to one address, interleaved with byte writes, return data reflecting every earlier-acked write; this ordering is guaranteed by the RAM.

## Configuration
- `ZAP_RAM_BEN_CTRL_INIT_EN` defined: INIT zero-fill runs after every reset; `o_init_done` rises after DEPTH unheld cycles.
- Undefined: the INIT state and counter are removed. The controller enters RUN directly from reset, with `o_init_done` = 1 from reset, and RAM contents are undefined.

## Test plan
- **Init.** With the macro, reset, DEPTH=32, requests asserted: no acks for 32 cycles, then `o_init_done` = 1; reads of addresses 0..31 return 0.
- **Basic read.** Write 0xDEADBEEF to address 5 with ben 4'hF; in the next cycle, requester 1 reads address 5: `o_rd_valid` = 2'b10 three cycles after the ack, with `o_rd_data` = 0xDEADBEEF.
- **Arbitration.** Both requesters request continuously for 6 cycles with `prio` = 0: the grant sequence is 0,1,0,1,0,1, and the valids return in the same order 3 cycles later.
- **Byte hazard.** Read address 3 in cycle T while writing ben 4'b0001 = 0x11 at T, 4'b0100 = 0x33 at T+1, and 4'b1000 = 0x44 at T+2, over prior contents 0xAABBCCDD: data at T+3 = 0x4433CC11.
- **Hold.** Ack a read at T; assert `i_hold` during T+1..T+2: valid appears at T+5, exactly once, with the correct data.
- **Reset mid-flight.** Assert `i_reset_n` = 0 with 3 reads in flight: `o_rd_valid` = 0 and `o_busy` = 0 immediately, and no stale valid appears after release.
